baccarat_sequencer: RTL and testbench
=====================================

BACCARAT_SEQUENCER -- requirements
Module: baccarat_sequencer

Interface
REQ-001 The block SHALL have port slow_clock, input, 1 bit: the single clock, rising-edge active.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port step, input, 1 bit: advance enable; the state changes only on edges where step=1.
REQ-004 The block SHALL have port pscore, input, 4 bits: player hand score, 0-9, valid the cycle after any player load.
REQ-005 The block SHALL have port dscore, input, 4 bits: dealer hand score, 0-9, valid the cycle after any dealer load.
REQ-006 The block SHALL have port pcard3, input, 4 bits: player third card code (1=A, 2-9, 10=T, 11=J, 12=Q, 13=K), valid the cycle after load_pcard3.
REQ-007 The block SHALL have outputs load_pcard1, load_pcard2, load_pcard3, each 1 bit: single-cycle player card register load strobes.
REQ-008 The block SHALL have outputs load_dcard1, load_dcard2, load_dcard3, each 1 bit: single-cycle dealer card register load strobes.
REQ-009 The block SHALL have outputs player_win_light and dealer_win_light, each 1 bit: registered result lights.
REQ-010 The block SHALL have output done, 1 bit: high while in state DONE.

Function
REQ-011 States SHALL be P1, D1, P2, D2, EVAL1, P3, EVAL2, D3, DONE; the reset state is P1.
REQ-012 Load strobes SHALL be combinational: asserted only when in the matching state (P1/P2/P3 for load_pcardN, D1/D2/D3 for load_dcardN) AND step=1, with at most one strobe high per cycle.
REQ-013 With step=1 the fixed deal sequence SHALL be P1->D1->P2->D2->EVAL1, one state per step.
REQ-014 With step=0 the state, lights and done SHALL hold, and all strobes SHALL be 0.
REQ-015 In EVAL1 with step=1, if pscore>=8 or dscore>=8 (natural), the next state SHALL be DONE.
REQ-016 Otherwise, in EVAL1, if pscore<=5 the next state SHALL be P3.
REQ-017 Otherwise, in EVAL1 (player stands on 6/7), the next state SHALL be D3 if dscore<=5, else DONE.
REQ-018 In EVAL2, v SHALL be the value of pcard3 (codes 1-9 map to 1-9; codes 10-13 map to 0), and the dealer SHALL draw (next state D3, else DONE) when: dscore 0-2 (any v); dscore 3 (v!=8); dscore 4 (v in 2..7); dscore 5 (v in 4..7); dscore 6 (v in 6..7); dscore 7 never.
REQ-019 P3 with step=1 SHALL go to EVAL2, and D3 with step=1 SHALL go to DONE.
REQ-020 On the edge entering DONE, the lights SHALL be registered from the current scores: player_win_light=(pscore>=dscore) and dealer_win_light=(dscore>=pscore); a tie sets both.
REQ-021 Because D3->DONE uses dscore before the third dealer card's score is valid, the lights for a D3 path SHALL instead be registered on the first step=1 edge while in DONE; DONE SHALL be absorbing until reset.
REQ-022 done SHALL be a registered decode of state==DONE.
REQ-023 The win-compare SHALL be 4-bit unsigned; scores >9 are out of contract and SHALL NOT cause a hang (the next state is always defined).
REQ-024 Unused state encodings SHALL go to P1 on the next edge.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL go to state P1 with player_win_light=0, dealer_win_light=0 and done=0, regardless of step.
REQ-026 Reset SHALL take priority over step, and load strobes SHALL be 0 in any cycle in which reset=1.
REQ-027 Reset asserted mid-hand (any state, including DONE) SHALL abandon the hand; the next deal SHALL restart at P1 with no strobe repeated from the aborted hand.

Verification
REQ-028 Natural: step held 1, with pscore=8 and dscore=3 at EVAL1 -> strobes P1,D1,P2,D2 in 4 consecutive cycles, then EVAL1->DONE, player_win=1, dealer_win=0, and load_pcard3/load_dcard3 never pulse.
REQ-029 Player stands: pscore=7, dscore=4 -> D3 strobes once, then DONE; with final dscore=7, both lights=1 (tie).
REQ-030 Third-card table: pscore=2 -> P3; sweep dscore 0..7 x pcard3 1..13 in EVAL2 and check the D3/DONE decision against REQ-018 (e.g. dscore=6 with pcard3=7 -> D3; dscore=6 with pcard3=12 -> DONE).
REQ-031 Stall: step toggles 1,0,0,1 during D1 -> load_dcard1 pulses only on step=1 cycles, and the state is unchanged across stalls.
REQ-032 Reset mid-hand: assert reset in P3 with step=1 -> no load_pcard3 pulse; the next cycle is P1, load_pcard1 fires on the next step, and lights=0, done=0.

Source files
------------

// File: rtl/baccarat_sequencer.sv
// -----------------------------------------------------------------------------
// baccarat_sequencer
//
// Control sequencer for one baccarat hand. It issues the card-register load
// strobes in deal order, applies the player and dealer third-card rules, and
// registers the win lights when the hand finishes.
//
// Ports
//   slow_clock        : single clock, rising-edge active
//   reset             : synchronous, active-high; returns the sequencer to P1
//   step              : advance enable; the state only moves on step=1 edges
//   pscore, dscore    : current player / dealer hand scores (0-9)
//   pcard3            : player third card code (1=A, 2-9, 10-13 = T/J/Q/K)
//   load_pcard1..3    : combinational single-cycle player card load strobes
//   load_dcard1..3    : combinational single-cycle dealer card load strobes
//   player_win_light  : registered, pscore >= dscore at the end of the hand
//   dealer_win_light  : registered, dscore >= pscore (a tie lights both)
//   done              : registered, high while the sequencer is in DONE
// -----------------------------------------------------------------------------
module baccarat_sequencer (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       done
);

    typedef enum logic [3:0] {
        P1    = 4'd0,
        D1    = 4'd1,
        P2    = 4'd2,
        D2    = 4'd3,
        EVAL1 = 4'd4,
        P3    = 4'd5,
        EVAL2 = 4'd6,
        D3    = 4'd7,
        DONE  = 4'd8
    } state_t;

    state_t state;
    state_t state_next;

    logic advance;        // step qualified by reset: strobes never fire during reset
    logic latch_lights;   // register the win lights on this edge
    logic set_pending;    // D3 -> DONE: lights must wait for the last dealer score
    logic lights_pending;

    assign advance = step & ~reset;

    // Face cards and tens count as zero; codes outside 1-13 are treated as zero.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        if (code >= 4'd1 && code <= 4'd9)
            card_value = code;
        else
            card_value = 4'd0;
    endfunction

    // Dealer third-card rule given the dealer score and the player's third card value.
    function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] v);
        case (ds)
            4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
            4'd3:             dealer_draws = (v != 4'd8);
            4'd4:             dealer_draws = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             dealer_draws = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             dealer_draws = (v >= 4'd6) && (v <= 4'd7);
            default:          dealer_draws = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_next   = state;
        load_pcard1  = 1'b0;
        load_pcard2  = 1'b0;
        load_pcard3  = 1'b0;
        load_dcard1  = 1'b0;
        load_dcard2  = 1'b0;
        load_dcard3  = 1'b0;
        latch_lights = 1'b0;
        set_pending  = 1'b0;

        case (state)
            P1: if (advance) begin
                load_pcard1 = 1'b1;
                state_next  = D1;
            end
            D1: if (advance) begin
                load_dcard1 = 1'b1;
                state_next  = P2;
            end
            P2: if (advance) begin
                load_pcard2 = 1'b1;
                state_next  = D2;
            end
            D2: if (advance) begin
                load_dcard2 = 1'b1;
                state_next  = EVAL1;
            end
            EVAL1: if (advance) begin
                if (pscore >= 4'd8 || dscore >= 4'd8) begin
                    state_next   = DONE;
                    latch_lights = 1'b1;
                end else if (pscore <= 4'd5) begin
                    state_next = P3;
                end else if (dscore <= 4'd5) begin
                    state_next = D3;
                end else begin
                    state_next   = DONE;
                    latch_lights = 1'b1;
                end
            end
            P3: if (advance) begin
                load_pcard3 = 1'b1;
                state_next  = EVAL2;
            end
            EVAL2: if (advance) begin
                if (dealer_draws(dscore, card_value(pcard3))) begin
                    state_next = D3;
                end else begin
                    state_next   = DONE;
                    latch_lights = 1'b1;
                end
            end
            D3: if (advance) begin
                load_dcard3 = 1'b1;
                state_next  = DONE;
                set_pending = 1'b1;
            end
            // DONE is absorbing; the only work left is the deferred light update.
            DONE: if (advance) begin
                latch_lights = lights_pending;
            end
            default: state_next = P1;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state            <= P1;
            done             <= 1'b0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            lights_pending   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
            if (latch_lights) begin
                player_win_light <= (pscore >= dscore);
                dealer_win_light <= (dscore >= pscore);
            end
            if (set_pending)
                lights_pending <= 1'b1;
            else if (latch_lights)
                lights_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_baccarat_sequencer
//
// Directed bench for baccarat_sequencer. Inputs change one time unit after a
// rising edge; combinational strobes are sampled after a further settle delay
// and registered outputs one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_baccarat_sequencer;

    logic       slow_clock;
    logic       reset;
    logic       step;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] strb;
    logic [1:0] lights;
    assign strb   = {load_pcard1, load_pcard2, load_pcard3,
                     load_dcard1, load_dcard2, load_dcard3};
    assign lights = {player_win_light, dealer_win_light};

    baccarat_sequencer dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .step             (step),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .done             (done)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step  = 1'b1;
        #1;
        chk("rst_strobes", {2'b0, strb}, 8'h00);
        tick();
        reset = 1'b0;
        step  = 1'b0;
        #1;
    endtask

    // From P1, step through the fixed deal and stop in EVAL1.
    task automatic deal();
        step = 1'b1;
        #1;
        chk("deal_p1", {2'b0, strb}, 8'b100000);
        tick();
        chk("deal_d1", {2'b0, strb}, 8'b000100);
        tick();
        chk("deal_p2", {2'b0, strb}, 8'b010000);
        tick();
        chk("deal_d2", {2'b0, strb}, 8'b000010);
        tick();
        chk("deal_eval1", {2'b0, strb}, 8'b000000);
    endtask

    // Independent statement of the dealer third-card table.
    function automatic logic exp_draw(input int ds, input int code);
        int v;
        v = (code <= 9) ? code : 0;
        if (ds <= 2)  return 1'b1;
        if (ds == 3)  return (v != 8);
        if (ds == 4)  return (v >= 2 && v <= 7);
        if (ds == 5)  return (v >= 4 && v <= 7);
        if (ds == 6)  return (v == 6 || v == 7);
        return 1'b0;
    endfunction

    initial begin
        reset  = 1'b1;
        step   = 1'b0;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;

        // Reset state
        tick();
        chk("reset_done",   {7'b0, done}, 8'd0);
        chk("reset_lights", {6'b0, lights}, 8'd0);
        do_reset();

        // Natural: player 8 vs dealer 3
        deal();
        pscore = 4'd8;
        dscore = 4'd3;
        #1;
        tick();
        chk("nat_done",   {7'b0, done}, 8'd1);
        chk("nat_lights", {6'b0, lights}, 8'b10);
        chk("nat_strobe_in_done", {2'b0, strb}, 8'd0);
        tick();
        chk("nat_absorb_done",   {7'b0, done}, 8'd1);
        chk("nat_absorb_lights", {6'b0, lights}, 8'b10);

        // Reset out of DONE clears everything
        do_reset();
        chk("rst_from_done_done",   {7'b0, done}, 8'd0);
        chk("rst_from_done_lights", {6'b0, lights}, 8'd0);

        // Player stands on 7, dealer 4 draws; final dealer score 7 ties
        deal();
        pscore = 4'd7;
        dscore = 4'd4;
        #1;
        tick();
        chk("stand_d3_done",   {7'b0, done}, 8'd0);
        chk("stand_d3_strobe", {2'b0, strb}, 8'b000001);
        tick();
        chk("stand_done",        {7'b0, done}, 8'd1);
        chk("stand_lights_wait", {6'b0, lights}, 8'b00);
        chk("stand_no_strobe",   {2'b0, strb}, 8'd0);
        dscore = 4'd7;
        #1;
        tick();
        chk("stand_tie_lights", {6'b0, lights}, 8'b11);
        dscore = 4'd2;
        #1;
        tick();
        chk("stand_lights_hold", {6'b0, lights}, 8'b11);
        chk("stand_done_hold",   {7'b0, done}, 8'd1);

        // Player 6 stands, dealer 7 stands -> dealer wins
        do_reset();
        deal();
        pscore = 4'd6;
        dscore = 4'd7;
        #1;
        tick();
        chk("p6d7_done",   {7'b0, done}, 8'd1);
        chk("p6d7_lights", {6'b0, lights}, 8'b01);

        // Player 7 stands, dealer 6 stands -> player wins
        do_reset();
        deal();
        pscore = 4'd7;
        dscore = 4'd6;
        #1;
        tick();
        chk("p7d6_done",   {7'b0, done}, 8'd1);
        chk("p7d6_lights", {6'b0, lights}, 8'b10);

        // Out-of-contract scores still reach DONE
        do_reset();
        deal();
        pscore = 4'd15;
        dscore = 4'd12;
        #1;
        tick();
        chk("ooc_done",   {7'b0, done}, 8'd1);
        chk("ooc_lights", {6'b0, lights}, 8'b10);

        // Stall in D1
        do_reset();
        step = 1'b1;
        #1;
        chk("stall_p1", {2'b0, strb}, 8'b100000);
        tick();
        step = 1'b0;
        #1;
        chk("stall_d1_s0a", {2'b0, strb}, 8'd0);
        tick();
        chk("stall_d1_s0b", {2'b0, strb}, 8'd0);
        tick();
        chk("stall_d1_s0c", {2'b0, strb}, 8'd0);
        step = 1'b1;
        #1;
        chk("stall_d1_s1", {2'b0, strb}, 8'b000100);
        tick();
        chk("stall_p2", {2'b0, strb}, 8'b010000);

        // Reset mid-hand while in P3 with step high
        do_reset();
        deal();
        pscore = 4'd3;
        dscore = 4'd3;
        #1;
        tick();
        chk("mid_p3_strobe", {2'b0, strb}, 8'b001000);
        reset = 1'b1;
        #1;
        chk("mid_rst_no_p3", {2'b0, strb}, 8'd0);
        tick();
        reset = 1'b0;
        step  = 1'b0;
        #1;
        chk("mid_after_done",   {7'b0, done}, 8'd0);
        chk("mid_after_lights", {6'b0, lights}, 8'd0);
        chk("mid_after_idle",   {2'b0, strb}, 8'd0);
        step = 1'b1;
        #1;
        chk("mid_restart_p1", {2'b0, strb}, 8'b100000);

        // Third-card table sweep: player 2 draws, dealer score 0..7 x card 1..13
        for (int ds = 0; ds <= 7; ds++) begin
            for (int code = 1; code <= 13; code++) begin
                do_reset();
                deal();
                pscore = 4'd2;
                dscore = 4'(ds);
                #1;
                tick();
                chk("sweep_p3", {2'b0, strb}, 8'b001000);
                tick();
                pcard3 = 4'(code);
                #1;
                tick();
                chk($sformatf("sweep_ds%0d_c%0d", ds, code),
                    {7'b0, done}, {7'b0, ~exp_draw(ds, code)});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
